// File: rtl/seq_multiplier_32.sv
// Unsigned radix-2 shift-add multiplier, P_WIDTH x P_WIDTH -> 2*P_WIDTH, start/done handshake.
// Latency P_WIDTH+1 edges start-to-done; with MUL_EARLY_TERM_EN defined it is 1+max(1, msb(B)+1).
// No backpressure: start is ignored while busy; product_out holds until the next done.
module seq_multiplier_32 #(
   parameter int P_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [P_WIDTH-1:0]     multiplicand_in,
   input  logic [P_WIDTH-1:0]     multiplier_in,
   output logic [2*P_WIDTH-1:0]   product_out,
   output logic                   busy,
   output logic                   done
);

   localparam int CNT_W = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [2*P_WIDTH-1:0] acc_q;
   logic [2*P_WIDTH-1:0] mcand_q;
   logic [2*P_WIDTH-1:0] acc_sum;
   logic [P_WIDTH-1:0]   mplier_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 last_bit;
   logic                 load;
   logic                 step;
   logic                 finish;

   // Partial-product accumulate for the current multiplier bit; cannot overflow 2*P_WIDTH bits.
   always_comb begin
      acc_sum = acc_q;
      if (mplier_q[0]) begin
         acc_sum = acc_q + mcand_q;
      end
   end

`ifdef MUL_EARLY_TERM_EN
   // Stop once no set bits remain above the one being processed this edge.
   always_comb begin
      last_bit = (cnt_q == CNT_LAST) || ((mplier_q >> 1) == '0);
   end
`else
   always_comb begin
      last_bit = (cnt_q == CNT_LAST);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_bit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy   = 1'b0;
      load   = 1'b0;
      step   = 1'b0;
      finish = 1'b0;
      case (state_q)
         IDLE: begin
            load = start;
         end
         RUN: begin
            busy   = 1'b1;
            step   = 1'b1;
            finish = last_bit;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
         product_out <= '0;
         done        <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            acc_q    <= '0;
            mcand_q  <= {{P_WIDTH{1'b0}}, multiplicand_in};
            mplier_q <= multiplier_in;
            cnt_q    <= '0;
         end else if (step) begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
         end
         if (finish) begin
            product_out <= acc_sum;
         end
      end
   end

endmodule

// File: tb/tb_seq_multiplier_32.sv
// Directed self-checking bench for seq_multiplier_32 (handshake, latency, results, reset abort).
module tb_seq_multiplier_32;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] multiplicand_in;
   logic [31:0] multiplier_in;
   logic [63:0] product_out;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   seq_multiplier_32 #(.P_WIDTH(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .multiplicand_in (multiplicand_in),
      .multiplier_in   (multiplier_in),
      .product_out     (product_out),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected start-to-done edge count (start-sampling edge counts as 1).
   function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
      int h;
      h = 0;
      for (int i = 0; i < 32; i++) begin
         if (b[i]) h = i + 1;
      end
      return 1 + ((h < 1) ? 1 : h);
`else
      return 33;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one start pulse and wait (bounded) for done; lat = -1 on timeout.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] prod, output logic busy_at_done);
      multiplicand_in = a;
      multiplier_in   = b;
      start           = 1'b1;
      tick();
      start           = 1'b0;
      multiplicand_in = 32'hDEAD_BEEF;
      multiplier_in   = 32'hCAFE_F00D;
      lat = 1;
      while (!done && lat < 200) begin
         tick();
         lat++;
      end
      if (!done) lat = -1;
      prod         = product_out;
      busy_at_done = busy;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      multiplicand_in = '0;
      multiplier_in   = '0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (product_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_product cycle %0d got %h want 0", i, product_out);
         end
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy cycle %0d got %b want 0", i, busy);
         end
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done cycle %0d got %b want 0", i, done);
         end
      end
   endtask

   task automatic test_basic();
      int lat;
      logic [63:0] prod;
      logic bsy;
      run_op(32'd7, 32'd6, lat, prod, bsy);
      checks++;
      if (lat !== exp_lat(32'd6)) begin
         errors++;
         $display("FAIL basic_latency got %0d want %0d", lat, exp_lat(32'd6));
      end
      checks++;
      if (prod !== 64'd42) begin
         errors++;
         $display("FAIL basic_product got %h want %h", prod, 64'd42);
      end
      checks++;
      if (bsy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_at_done got %b want 0", bsy);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_one_cycle got %b want 0", done);
      end
      repeat (3) tick();
      checks++;
      if (product_out !== 64'd42) begin
         errors++;
         $display("FAIL basic_product_held got %h want %h", product_out, 64'd42);
      end
   endtask

   task automatic test_extremes();
      int lat;
      logic [63:0] prod;
      logic bsy;
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, prod, bsy);
      checks++;
      if (lat !== exp_lat(32'hFFFF_FFFF)) begin
         errors++;
         $display("FAIL max_latency got %0d want %0d", lat, exp_lat(32'hFFFF_FFFF));
      end
      checks++;
      if (prod !== 64'hFFFF_FFFE_0000_0001) begin
         errors++;
         $display("FAIL max_product got %h want %h", prod, 64'hFFFF_FFFE_0000_0001);
      end
      tick();
      run_op(32'h1234_5678, 32'd0, lat, prod, bsy);
      checks++;
      if (lat !== exp_lat(32'd0)) begin
         errors++;
         $display("FAIL zero_latency got %0d want %0d", lat, exp_lat(32'd0));
      end
      checks++;
      if (prod !== 64'd0) begin
         errors++;
         $display("FAIL zero_product got %h want 0", prod);
      end
      run_op(32'hABCD_0001, 32'h0000_0003, lat, prod, bsy);
      checks++;
      if (prod !== 64'h0000_0002_0367_0003) begin
         errors++;
         $display("FAIL mixed_product got %h want %h", prod, 64'h0000_0002_0367_0003);
      end
      tick();
   endtask

   task automatic test_ignore_start();
      int dones;
      int pulse_at;
      logic [63:0] last_prod;
`ifdef MUL_EARLY_TERM_EN
      pulse_at = 2;
`else
      pulse_at = 10;
`endif
      dones = 0;
      last_prod = '0;
      multiplicand_in = 32'd3;
      multiplier_in   = 32'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 45; c++) begin
         if (c == pulse_at) begin
            multiplicand_in = 32'd9;
            multiplier_in   = 32'd9;
            start = 1'b1;
         end
         tick();
         start = 1'b0;
         if (done) begin
            dones++;
            last_prod = product_out;
         end
      end
      checks++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL ignore_start_done_count got %0d want 1", dones);
      end
      checks++;
      if (last_prod !== 64'd15) begin
         errors++;
         $display("FAIL ignore_start_product got %h want %h", last_prod, 64'd15);
      end
   endtask

   task automatic test_back_to_back();
      int gap;
      multiplicand_in = 32'h0001_0000;
      multiplier_in   = 32'h0001_0000;
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         gap = 0;
         do begin
            tick();
            gap++;
         end while (!done && gap < 200);
         checks++;
         if (gap !== exp_lat(32'h0001_0000)) begin
            errors++;
            $display("FAIL b2b_interval_%0d got %0d want %0d", k, gap, exp_lat(32'h0001_0000));
         end
         checks++;
         if (product_out !== 64'h0000_0001_0000_0000) begin
            errors++;
            $display("FAIL b2b_product_%0d got %h want %h", k, product_out, 64'h0000_0001_0000_0000);
         end
      end
      start = 1'b0;
      tick();
   endtask

   task automatic test_reset_abort();
      int dones;
      int rst_at;
      int lat;
      logic [63:0] prod;
      logic bsy;
`ifdef MUL_EARLY_TERM_EN
      rst_at = 2;
`else
      rst_at = 12;
`endif
      multiplicand_in = 32'd5;
      multiplier_in   = 32'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (rst_at - 1) tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_busy_before_rst got %b want 1", busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy got %b want 0", busy);
      end
      checks++;
      if (product_out !== 64'd0) begin
         errors++;
         $display("FAIL abort_product got %h want 0", product_out);
      end
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) dones++;
         tick();
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL abort_no_done got %0d want 0", dones);
      end
      run_op(32'd5, 32'd5, lat, prod, bsy);
      checks++;
      if (lat !== exp_lat(32'd5)) begin
         errors++;
         $display("FAIL abort_restart_latency got %0d want %0d", lat, exp_lat(32'd5));
      end
      checks++;
      if (prod !== 64'd25) begin
         errors++;
         $display("FAIL abort_restart_product got %h want %h", prod, 64'd25);
      end
      tick();
   endtask

`ifdef MUL_EARLY_TERM_EN
   task automatic test_early_term();
      int lat;
      logic [63:0] prod;
      logic bsy;
      run_op(32'd100, 32'd1, lat, prod, bsy);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL early_b1_latency got %0d want 2", lat);
      end
      checks++;
      if (prod !== 64'd100) begin
         errors++;
         $display("FAIL early_b1_product got %h want %h", prod, 64'd100);
      end
      tick();
      run_op(32'd2, 32'h8000_0000, lat, prod, bsy);
      checks++;
      if (lat !== 33) begin
         errors++;
         $display("FAIL early_msb_latency got %0d want 33", lat);
      end
      checks++;
      if (prod !== 64'h0000_0001_0000_0000) begin
         errors++;
         $display("FAIL early_msb_product got %h want %h", prod, 64'h0000_0001_0000_0000);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
`ifdef MUL_EARLY_TERM_EN
      test_early_term();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
